rs_wakeup_select: RTL and testbench
===================================

Name: rs_wakeup_select

Overview:
- Parametrised successor to the ALU reservation station.
- Holds DEPTH renamed ALU ops waiting on source operands.
- Wakes operands from NUM_CDB broadcast ports in parallel, including same-cycle bypass on allocation.
- Issues the oldest ready entry to the functional unit over a valid/ready handshake. An entry is freed on issue, not on result broadcast.

Parameters:
- DEPTH, 8, number of entries (>=2).
- TAG_W, 4, ROB tag width.
- DATA_W, 32, operand width (>= TAG_W).
- OP_W, 5, opaque opcode field width; not decoded.
- NUM_CDB, 2, number of parallel broadcast ports.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries
- alloc_valid  in  1  dispatch request
- alloc_ready  out  1  at least one free entry
- alloc_tag  in  TAG_W  destination ROB tag
- alloc_op  in  OP_W  opcode payload
- alloc_src1_busy  in  1  src1 is a pending tag (1) or a value (0)
- alloc_src1  in  DATA_W  src1 value, or tag in [TAG_W-1:0] when busy
- alloc_src2_busy  in  1  as src1
- alloc_src2  in  DATA_W  as src1
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  port p at [p*TAG_W +: TAG_W]
- cdb_data  in  NUM_CDB*DATA_W  port p at [p*DATA_W +: DATA_W]
- issue_valid  out  1  a ready entry is presented
- issue_ready  in  1  functional unit accepts
- issue_tag  out  TAG_W  tag of the selected entry
- issue_op  out  OP_W  opcode of the selected entry
- issue_src1  out  DATA_W  resolved src1
- issue_src2  out  DATA_W  resolved src2
- num_free  out  $clog2(DEPTH+1)  count of free entries

Behaviour:
- Reset (rst=0, async):
  - all entries invalid; age state cleared.
  - outputs: num_free=DEPTH, alloc_ready=1, issue_valid=0, issue_tag/op/src=0.
- Per-entry state: valid, tag, op, busy1/2, src1/2; plus an age matrix (DEPTH x DEPTH, older-than bits).
- Allocation:
  - Fires on alloc_valid && alloc_ready.
  - Writes the lowest-index entry that is free at the start of the cycle.
  - A slot freed by issue in the same cycle is not reused until the next cycle.
  - The new entry is marked younger than every valid entry.
  - alloc_valid while alloc_ready=0 is ignored; no state change.
- Allocation bypass (per source):
  - Applies if busy and some cdb_valid[p] has cdb_tag[p]==src[TAG_W-1:0].
  - The entry stores cdb_data[p] with busy=0.
- Wakeup (each valid entry, each busy source):
  - A matching valid CDB port sets src<=cdb_data, busy<=0 at the clock edge.
  - Both sources may wake in the same cycle from different ports.
  - If several ports match the same tag, the lowest port index wins.
- Ready: entry valid && !busy1 && !busy2, evaluated from registered state only.
  - A source woken this cycle makes the entry ready next cycle; wake-to-issue latency is 1 cycle.
  - An allocated entry is earliest eligible the cycle after allocation.
- Select (combinational):
  - issue_valid = any ready entry && !flush.
  - Outputs come from the oldest ready entry per the age matrix.
  - Outputs hold stable while issue_valid && !issue_ready; the selection may change only if an older entry becomes ready.
- Issue: on issue_valid && issue_ready, the selected entry goes invalid at the edge.
- CDB results never free entries; the freeing rule is issue only.
- num_free and alloc_ready are combinational from registered valid bits (start-of-cycle view).
- Flush:
  - All entries go invalid at the edge; num_free=DEPTH next cycle.
  - Overrides a same-cycle alloc, wakeup and issue; an issue handshake during flush is not counted.
  - issue_valid is forced 0 in the flush cycle.
- Tag width: CDB matching compares only TAG_W bits; upper src bits are don't-care while busy.
- No combinational path from issue_ready to alloc_ready, or from issue_ready to num_free.

Test Plan:
- Reset, then alloc tag=3, op=2, src1=0x10, src2=0x20, both not busy:
  - num_free 8->7;
  - next cycle issue_valid=1, issue_tag=3, issue_src1=0x10, issue_src2=0x20;
  - with issue_ready=1, num_free returns to 8.
- Wakeup:
  - alloc tag=5, src1 busy on tag 2, src2 busy on tag 7 → no issue.
  - Same cycle, cdb0 {tag 2, 0xAAAA} and cdb1 {tag 7, 0xBBBB}.
  - Next cycle issue_valid=1 with src1=0xAAAA, src2=0xBBBB.
- Allocation bypass: alloc src1 busy tag 9 while cdb1 broadcasts tag 9 / 0x1234 in the same cycle → entry issues next cycle with src1=0x1234.
- Age order:
  - allocate A(tag1), B(tag2), C(tag3), all waiting on tag 6; hold issue_ready=0.
  - broadcast tag 6 → issue_tag=1 held stable.
  - Then with issue_ready=1, order of issue is 1, 2, 3.
- Full/wrap:
  - 8 allocs → alloc_ready=0, num_free=0; 9th alloc ignored.
  - One issue frees slot k; the next alloc lands in slot k and is youngest.
- Flush and reset mid-operation:
  - flush with 5 valid entries plus a simultaneous alloc and issue handshake → next cycle num_free=8, issue_valid=0.
  - Async rst low mid-cycle → outputs go to reset values immediately.

Source files
------------

// File: rtl/rs_wakeup_select_if.sv
`default_nettype none
// ============================================================================
// Module   : rs_wakeup_select_if
// Purpose  : Bundles the dispatch (alloc), result broadcast (cdb) and issue
//            handshakes of the wakeup/select reservation station.
// Ports    : alloc_*  - dispatch request, payload and ready/free status
//            cdb_*    - NUM_CDB parallel result broadcast ports (packed)
//            issue_*  - valid/ready handshake toward the functional unit
//            num_free - count of free entries
// Modports : master - the side driving dispatch/broadcast and consuming issue
//            slave  - the reservation station itself
// Revision : 1.0 - initial release
// ============================================================================
interface rs_wakeup_select_if #(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int NUM_CDB = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [TAG_W-1:0]          alloc_tag;
  logic [OP_W-1:0]           alloc_op;
  logic                      alloc_src1_busy;
  logic [DATA_W-1:0]         alloc_src1;
  logic                      alloc_src2_busy;
  logic [DATA_W-1:0]         alloc_src2;

  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;

  logic                      issue_valid;
  logic                      issue_ready;
  logic [TAG_W-1:0]          issue_tag;
  logic [OP_W-1:0]           issue_op;
  logic [DATA_W-1:0]         issue_src1;
  logic [DATA_W-1:0]         issue_src2;

  logic [CNT_W-1:0]          num_free;

  modport master (
    output alloc_valid, alloc_tag, alloc_op,
           alloc_src1_busy, alloc_src1, alloc_src2_busy, alloc_src2,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  alloc_ready, issue_valid, issue_tag, issue_op,
           issue_src1, issue_src2, num_free
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_op,
           alloc_src1_busy, alloc_src1, alloc_src2_busy, alloc_src2,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output alloc_ready, issue_valid, issue_tag, issue_op,
           issue_src1, issue_src2, num_free
  );
endinterface
`default_nettype wire

// File: rtl/rs_wakeup_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_wakeup_select
// Purpose  : DEPTH-entry ALU reservation station. Entries wait for busy
//            source operands, wake from NUM_CDB parallel broadcast ports
//            (with same-cycle bypass on allocation) and the oldest ready
//            entry is issued over a valid/ready handshake. Entries are freed
//            on issue only.
// Ports    : clk   - clock
//            rst   - asynchronous active-low reset
//            flush - synchronous squash of all entries
//            rs    - slave modport of rs_wakeup_select_if (alloc, cdb, issue,
//                    num_free)
// Revision : 1.0 - initial release
// ============================================================================
module rs_wakeup_select #(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int NUM_CDB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  rs_wakeup_select_if.slave rs
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry storage
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_busy1;
  logic [DEPTH-1:0]  r_busy2;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [DATA_W-1:0] r_src1 [DEPTH];
  logic [DATA_W-1:0] r_src2 [DEPTH];
  // r_older[i][j] = 1 means entry i is older than entry j. Diagonal stays 0.
  logic [DEPTH-1:0]  r_older [DEPTH];

  logic [DATA_W:0]   w_wk1 [DEPTH];   // {hit, data} wakeup lookup, src1
  logic [DATA_W:0]   w_wk2 [DEPTH];   // {hit, data} wakeup lookup, src2
  logic [DATA_W:0]   w_byp1;
  logic [DATA_W:0]   w_byp2;
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_sel;
  logic [DEPTH-1:0]  w_alloc_oh;
  logic [CNT_W-1:0]  w_num_free;
  logic              w_any_free;
  logic              w_alloc_fire;
  logic              w_issue_valid;
  logic              w_issue_fire;
  logic [TAG_W-1:0]  w_issue_tag;
  logic [OP_W-1:0]   w_issue_op;
  logic [DATA_W-1:0] w_issue_src1;
  logic [DATA_W-1:0] w_issue_src2;

  // Broadcast lookup: scan from the highest port down so the lowest-index
  // matching port is the one left in the result.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, data[p*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = cdb_lookup(r_src1[i][TAG_W-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
      w_wk2[i] = cdb_lookup(r_src2[i][TAG_W-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
    end
    w_byp1 = cdb_lookup(rs.alloc_src1[TAG_W-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
    w_byp2 = cdb_lookup(rs.alloc_src2[TAG_W-1:0], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
  end

  // Readiness uses registered state only, giving a 1-cycle wake-to-issue.
  assign w_ready = r_valid & ~r_busy1 & ~r_busy2;

  // Oldest-ready select: an entry is chosen if no other ready entry is older.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (w_ready[j] && r_older[j][i]) begin
          w_sel[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_issue_tag  = '0;
    w_issue_op   = '0;
    w_issue_src1 = '0;
    w_issue_src2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) begin
        w_issue_tag  = r_tag[i];
        w_issue_op   = r_op[i];
        w_issue_src1 = r_src1[i];
        w_issue_src2 = r_src2[i];
      end
    end
  end

  assign w_issue_valid = (|w_ready) && !flush;
  assign w_issue_fire  = w_issue_valid && rs.issue_ready;

  // Free-slot view is taken from registered valid bits only, so a slot
  // released by this cycle's issue is not reused until the next cycle and
  // issue_ready has no path to alloc_ready/num_free.
  assign w_alloc_oh   = ~r_valid & (r_valid + DEPTH'(1));  // lowest clear bit
  assign w_any_free   = ~&r_valid;
  assign w_alloc_fire = rs.alloc_valid && w_any_free;

  always_comb begin
    w_num_free = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i]) begin
        w_num_free = w_num_free + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_busy1 <= '0;
      r_busy2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]   <= '0;
        r_op[i]    <= '0;
        r_src1[i]  <= '0;
        r_src2[i]  <= '0;
        r_older[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && r_busy1[i] && w_wk1[i][DATA_W]) begin
          r_src1[i]  <= w_wk1[i][DATA_W-1:0];
          r_busy1[i] <= 1'b0;
        end
        if (r_valid[i] && r_busy2[i] && w_wk2[i][DATA_W]) begin
          r_src2[i]  <= w_wk2[i][DATA_W-1:0];
          r_busy2[i] <= 1'b0;
        end
        if (w_issue_fire && w_sel[i]) begin
          r_valid[i] <= 1'b0;
        end
        if (w_alloc_fire) begin
          if (w_alloc_oh[i]) begin
            // New entry: older than nothing, younger than everyone else.
            r_valid[i] <= 1'b1;
            r_tag[i]   <= rs.alloc_tag;
            r_op[i]    <= rs.alloc_op;
            r_busy1[i] <= rs.alloc_src1_busy && !w_byp1[DATA_W];
            r_src1[i]  <= (rs.alloc_src1_busy && w_byp1[DATA_W]) ?
                          w_byp1[DATA_W-1:0] : rs.alloc_src1;
            r_busy2[i] <= rs.alloc_src2_busy && !w_byp2[DATA_W];
            r_src2[i]  <= (rs.alloc_src2_busy && w_byp2[DATA_W]) ?
                          w_byp2[DATA_W-1:0] : rs.alloc_src2;
            r_older[i] <= '0;
          end else begin
            r_older[i] <= r_older[i] | w_alloc_oh;
          end
        end
      end
    end
  end

  assign rs.alloc_ready = w_any_free;
  assign rs.num_free    = w_num_free;
  assign rs.issue_valid = w_issue_valid;
  assign rs.issue_tag   = w_issue_tag;
  assign rs.issue_op    = w_issue_op;
  assign rs.issue_src1  = w_issue_src1;
  assign rs.issue_src2  = w_issue_src2;

endmodule
`default_nettype wire

// File: tb/tb_rs_wakeup_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_wakeup_select
// Purpose  : Self-checking bench for rs_wakeup_select. A reference model
//            keeps the waiting ops as an age-ordered queue (oldest first);
//            a driver pushes expected per-cycle status and expected issues
//            into queues, and a monitor compares them against the DUT.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_wakeup_select;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 5;
  localparam int NUM_CDB = 2;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  rs_wakeup_select_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                        .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

  rs_wakeup_select #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
                     .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .rs    (bus)
  );

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
    logic              b1;
    logic              b2;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
  } ent_t;

  typedef struct {
    logic              is_rst;
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [3:0]        nfree;
    logic              ardy;
  } stat_t;

  ent_t  model [$];   // waiting ops, oldest first
  stat_t stat_q [$];  // expected status, one per cycle
  ent_t  iss_q [$];   // expected issued ops, one per handshake
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First (lowest-numbered) broadcast port carrying tag t, if any.
  function automatic bit cdb_match(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (bus.cdb_valid[p] && bus.cdb_tag[p*TAG_W +: TAG_W] == t) begin
        d = bus.cdb_data[p*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic idle();
    flush               = 1'b0;
    bus.alloc_valid     = 1'b0;
    bus.alloc_tag       = '0;
    bus.alloc_op        = '0;
    bus.alloc_src1_busy = 1'b0;
    bus.alloc_src1      = '0;
    bus.alloc_src2_busy = 1'b0;
    bus.alloc_src2      = '0;
    bus.cdb_valid       = '0;
    bus.cdb_tag         = '0;
    bus.cdb_data        = '0;
  endtask

  task automatic alloc_set(input int tag, input int op, input bit b1, input logic [DATA_W-1:0] s1,
                           input bit b2, input logic [DATA_W-1:0] s2);
    bus.alloc_valid     = 1'b1;
    bus.alloc_tag       = TAG_W'(tag);
    bus.alloc_op        = OP_W'(op);
    bus.alloc_src1_busy = b1;
    bus.alloc_src1      = s1;
    bus.alloc_src2_busy = b2;
    bus.alloc_src2      = s2;
  endtask

  task automatic cdb_set(input int p, input int tag, input logic [DATA_W-1:0] data);
    bus.cdb_valid[p]                 = 1'b1;
    bus.cdb_tag[p*TAG_W +: TAG_W]    = TAG_W'(tag);
    bus.cdb_data[p*DATA_W +: DATA_W] = data;
  endtask

  // Predict this cycle's outputs from the model, advance the model across
  // the next clock edge, then move to 1 time unit after that edge.
  task automatic step();
    stat_t             s;
    ent_t              e;
    ent_t              n;
    int                rdy;
    int                sz0;
    logic              fire;
    logic [DATA_W-1:0] d;
    rdy = -1;
    for (int i = 0; i < model.size(); i++)
      if (rdy < 0 && !model[i].b1 && !model[i].b2) rdy = i;
    s.tag = '0; s.op = '0; s.s1 = '0; s.s2 = '0;
    if (!rst) begin
      s.is_rst = 1'b1;
      s.valid  = 1'b0;
      s.nfree  = 4'(DEPTH);
      s.ardy   = 1'b1;
      model.delete();
    end else begin
      s.is_rst = 1'b0;
      s.valid  = (rdy >= 0) && !flush;
      s.nfree  = 4'(DEPTH - model.size());
      s.ardy   = (model.size() < DEPTH);
      if (rdy >= 0) begin
        e = model[rdy];
        s.tag = e.tag; s.op = e.op; s.s1 = e.s1; s.s2 = e.s2;
      end
      if (flush) begin
        model.delete();
      end else begin
        sz0  = model.size();
        fire = s.valid && bus.issue_ready;
        if (fire) iss_q.push_back(model[rdy]);
        for (int i = 0; i < model.size(); i++) begin
          e = model[i];
          if (e.b1 && cdb_match(e.s1[TAG_W-1:0], d)) begin e.s1 = d; e.b1 = 1'b0; end
          if (e.b2 && cdb_match(e.s2[TAG_W-1:0], d)) begin e.s2 = d; e.b2 = 1'b0; end
          model[i] = e;
        end
        if (fire) model.delete(rdy);
        if (bus.alloc_valid && sz0 < DEPTH) begin
          n.tag = bus.alloc_tag;  n.op = bus.alloc_op;
          n.b1  = bus.alloc_src1_busy; n.s1 = bus.alloc_src1;
          n.b2  = bus.alloc_src2_busy; n.s2 = bus.alloc_src2;
          if (n.b1 && cdb_match(n.s1[TAG_W-1:0], d)) begin n.s1 = d; n.b1 = 1'b0; end
          if (n.b2 && cdb_match(n.s2[TAG_W-1:0], d)) begin n.s2 = d; n.b2 = 1'b0; end
          model.push_back(n);
        end
      end
    end
    stat_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle comparison of status and of each issue handshake.
  stat_t ms;
  ent_t  me;
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      ms = stat_q.pop_front();
      chk("issue_valid", 64'(bus.issue_valid), 64'(ms.valid));
      chk("num_free",    64'(bus.num_free),    64'(ms.nfree));
      chk("alloc_ready", 64'(bus.alloc_ready), 64'(ms.ardy));
      if (ms.valid || ms.is_rst) begin
        chk("sel_tag",  64'(bus.issue_tag),  64'(ms.tag));
        chk("sel_op",   64'(bus.issue_op),   64'(ms.op));
        chk("sel_src1", 64'(bus.issue_src1), 64'(ms.s1));
        chk("sel_src2", 64'(bus.issue_src2), 64'(ms.s2));
      end
      if (bus.issue_valid && bus.issue_ready) begin
        if (iss_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_issue: got tag 0x%0h expected no issue at %0t",
                   bus.issue_tag, $time);
        end else begin
          me = iss_q.pop_front();
          chk("issue_tag",  64'(bus.issue_tag),  64'(me.tag));
          chk("issue_op",   64'(bus.issue_op),   64'(me.op));
          chk("issue_src1", 64'(bus.issue_src1), 64'(me.s1));
          chk("issue_src2", 64'(bus.issue_src2), 64'(me.s2));
        end
      end
    end
  end

  initial begin
    idle();
    bus.issue_ready = 1'b0;
    @(posedge clk);
    #1;
    step(); step();
    rst = 1'b1;
    step();

    // Basic alloc then issue
    alloc_set(3, 2, 0, 32'h10, 0, 32'h20); step();
    idle(); bus.issue_ready = 1'b1; step(); step();

    // Both sources resolved by broadcast in the allocation cycle
    alloc_set(5, 1, 1, 32'h2, 1, 32'h7);
    cdb_set(0, 2, 32'hAAAA); cdb_set(1, 7, 32'hBBBB); step();
    idle(); step(); step();

    // Wakeup of a stored entry, two ports, lowest port wins on shared tag
    alloc_set(6, 4, 1, 32'hFFFF_FFF2, 1, 32'h3); step();
    idle(); step();
    cdb_set(0, 3, 32'hC0DE); cdb_set(1, 2, 32'hBEEF); step();
    idle(); step();
    alloc_set(7, 5, 1, 32'h1, 1, 32'h1); step();
    idle(); cdb_set(0, 1, 32'h1111); cdb_set(1, 1, 32'h2222); step();
    idle(); step(); step();

    // Allocation bypass on src1
    alloc_set(4, 3, 1, 32'h9, 0, 32'h55); cdb_set(1, 9, 32'h1234); step();
    idle(); step(); step();

    // Age order with issue held off
    bus.issue_ready = 1'b0;
    alloc_set(1, 1, 1, 32'h6, 0, 32'h0); step();
    alloc_set(2, 2, 1, 32'h6, 0, 32'h0); step();
    alloc_set(3, 3, 1, 32'h6, 0, 32'h0); step();
    idle(); cdb_set(0, 6, 32'h6666); step();
    idle(); step(); step(); step();
    bus.issue_ready = 1'b1; step(); step(); step(); step();

    // Fill, overflow attempt, free one slot, refill, drain
    bus.issue_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      alloc_set(k, k, 1, 32'(8 + k), 0, 32'(k)); step();
    end
    alloc_set(15, 9, 0, 32'h99, 0, 32'h99); step();
    idle(); cdb_set(0, 12, 32'hC12); step();
    idle(); bus.issue_ready = 1'b1; step();
    bus.issue_ready = 1'b0;
    alloc_set(14, 7, 0, 32'hE1, 0, 32'hE2); step();
    idle(); step();
    bus.issue_ready = 1'b1;
    idle(); cdb_set(0, 15, 32'hF5); cdb_set(1, 8, 32'h80); step();
    idle(); cdb_set(0, 10, 32'hA0); cdb_set(1, 9, 32'h90); step();
    idle(); cdb_set(0, 11, 32'hB0); cdb_set(1, 13, 32'hD0); step();
    idle(); cdb_set(0, 14, 32'hE0); step();
    idle(); repeat (10) step();

    // Flush with a simultaneous alloc and issue handshake
    bus.issue_ready = 1'b0;
    alloc_set(1, 1, 0, 32'h1, 0, 32'h1); step();
    for (int k = 2; k <= 5; k++) begin
      alloc_set(k, k, 1, 32'hF, 0, 32'h0); step();
    end
    alloc_set(8, 8, 0, 32'h8, 0, 32'h8); bus.issue_ready = 1'b1; flush = 1'b1; step();
    idle(); step(); step();

    // Asynchronous reset in mid-cycle
    bus.issue_ready = 1'b0;
    alloc_set(2, 2, 0, 32'h22, 0, 32'h23); step();
    alloc_set(3, 3, 0, 32'h33, 0, 32'h34); step();
    idle(); step();
    rst = 1'b0;
    #1;
    chk("async_num_free",    64'(bus.num_free),    64'(DEPTH));
    chk("async_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("async_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    chk("async_issue_tag",   64'(bus.issue_tag),   64'd0);
    step();
    rst = 1'b1;
    step();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      bus.alloc_valid     = ($urandom_range(0, 2) != 0);
      bus.alloc_tag       = TAG_W'($urandom);
      bus.alloc_op        = OP_W'($urandom);
      bus.alloc_src1_busy = ($urandom_range(0, 2) != 0);
      bus.alloc_src1      = $urandom;
      bus.alloc_src2_busy = ($urandom_range(0, 2) != 0);
      bus.alloc_src2      = $urandom;
      bus.cdb_valid       = NUM_CDB'($urandom);
      bus.cdb_tag         = (NUM_CDB*TAG_W)'($urandom);
      for (int p = 0; p < NUM_CDB; p++) bus.cdb_data[p*DATA_W +: DATA_W] = $urandom;
      bus.issue_ready     = ($urandom_range(0, 3) != 0);
      flush               = ($urandom_range(0, 99) == 0);
      step();
    end

    idle(); bus.issue_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    #1;
    n_cmp++;
    if (iss_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_issues: got %0d outstanding expected 0", iss_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
